// File: rtl/iir_sos_coeff_bank.sv
// Double-buffered SOS IIR coefficient store with atomic bank swap.
// Define IIR_COEF_CHECKSUM_EN to require a trailing checksum word per load.
module iir_sos_coeff_bank #(
    parameter int IIR_WD     = 48,
    parameter int COF_WD     = 32,
    parameter int SOS_NUM    = 6,
    parameter int FRAC_SHIFT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    input  logic [COF_WD-1:0]          ld_data,
    output logic                       ld_ready,
    output logic                       ld_done,
    output logic                       ld_err,
    input  logic                       swap_req,
    output logic                       swap_ack,
    input  logic                       rd_en,
    input  logic [$clog2(SOS_NUM)-1:0] rd_sec,
    output logic                       rd_valid,
    output logic [IIR_WD-1:0]          rd_b0,
    output logic [IIR_WD-1:0]          rd_b1,
    output logic [IIR_WD-1:0]          rd_b2,
    output logic [IIR_WD-1:0]          rd_a1,
    output logic [IIR_WD-1:0]          rd_a2,
    output logic                       bank_sel
);

    localparam int NW = 5 * SOS_NUM;
    localparam int AW = $clog2(NW);
    localparam int CW = $clog2(NW + 1);
    localparam int SW = $clog2(SOS_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_bank_sel;
    logic              r_done;
    logic              r_err;
    logic              r_ack;
    logic [IIR_WD-1:0] r_bank [2][NW];

    logic              r_rd_valid;
    logic [IIR_WD-1:0] r_b0;
    logic [IIR_WD-1:0] r_b1;
    logic [IIR_WD-1:0] r_b2;
    logic [IIR_WD-1:0] r_a1;
    logic [IIR_WD-1:0] r_a2;

`ifdef IIR_COEF_CHECKSUM_EN
    logic [COF_WD-1:0] r_sum;
`endif

    logic [IIR_WD-1:0] w_wide;
    logic              w_shadow;
    logic              w_last;
    logic [AW-1:0]     w_base;
    logic              w_sec_ok;

    // Sign-extend first so the fractional alignment keeps the sign.
    assign w_wide   = IIR_WD'($signed(ld_data)) << FRAC_SHIFT;
    assign w_shadow = ~r_bank_sel;
    assign w_last   = (r_cnt == CW'(NW - 1));
    assign w_base   = AW'(rd_sec) * AW'(5);
    assign w_sec_ok = ({1'b0, rd_sec} < (SW + 1)'(SOS_NUM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bank_sel <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ack      <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NW; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
`ifdef IIR_COEF_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_ack  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ld_start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
`ifdef IIR_COEF_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (ld_start) begin
                        r_cnt <= '0;
                        r_err <= 1'b1;
`ifdef IIR_COEF_CHECKSUM_EN
                        r_sum <= '0;
`endif
                    end else if (ld_valid) begin
`ifdef IIR_COEF_CHECKSUM_EN
                        if (r_cnt == CW'(NW)) begin
                            if (ld_data == r_sum) begin
                                r_state <= S_FULL;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_bank[w_shadow][AW'(r_cnt)] <= w_wide;
                            r_cnt <= r_cnt + CW'(1);
                            r_sum <= r_sum + ld_data;
                        end
`else
                        r_bank[w_shadow][AW'(r_cnt)] <= w_wide;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state <= S_FULL;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end
                S_FULL: begin
                    // Swap wins over a simultaneous restart.
                    if (swap_req) begin
                        r_bank_sel <= ~r_bank_sel;
                        r_ack      <= 1'b1;
                        r_state    <= ld_start ? S_LOAD : S_IDLE;
                        r_cnt      <= '0;
`ifdef IIR_COEF_CHECKSUM_EN
                        r_sum      <= '0;
`endif
                    end else if (ld_start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
`ifdef IIR_COEF_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
        end else if (rd_en) begin
            r_rd_valid <= 1'b1;
            if (w_sec_ok) begin
                r_b0 <= r_bank[r_bank_sel][w_base];
                r_b1 <= r_bank[r_bank_sel][w_base + AW'(1)];
                r_b2 <= r_bank[r_bank_sel][w_base + AW'(2)];
                r_a1 <= r_bank[r_bank_sel][w_base + AW'(3)];
                r_a2 <= r_bank[r_bank_sel][w_base + AW'(4)];
            end else begin
                r_b0 <= '0;
                r_b1 <= '0;
                r_b2 <= '0;
                r_a1 <= '0;
                r_a2 <= '0;
            end
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign ld_ready = (r_state == S_LOAD);
    assign ld_done  = r_done;
    assign ld_err   = r_err;
    assign swap_ack = r_ack;
    assign bank_sel = r_bank_sel;
    assign rd_valid = r_rd_valid;
    assign rd_b0    = r_b0;
    assign rd_b1    = r_b1;
    assign rd_b2    = r_b2;
    assign rd_a1    = r_a1;
    assign rd_a2    = r_a2;

endmodule

// File: doc/iir_sos_coeff_bank.md
Name: iir_sos_coeff_bank

Overview:
- Double-buffered coefficient store for the cascade SOS IIR datapath, parametrised in section count and coefficient/datapath widths.
- A host streams COF_WD coefficients into a shadow bank over a valid/ready handshake.
- The filter reads the active bank per section, with coefficients widened and aligned to IIR_WD.
- A swap request commits the shadow bank atomically, so the filter never sees a half-loaded coefficient set.

Parameters:
- IIR_WD, 48, datapath word width of read outputs.
- COF_WD, 32, width of loaded coefficient words.
- SOS_NUM, 6, number of second-order sections.
- FRAC_SHIFT, 16, left shift applied when widening COF_WD to IIR_WD; COF_WD+FRAC_SHIFT <= IIR_WD is required.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  pulse; begin a new shadow load.
- ld_valid  in  1  ld_data valid.
- ld_data  in  COF_WD  signed coefficient word.
- ld_ready  out  1  block accepts ld_data.
- ld_done  out  1  one-cycle pulse; shadow complete.
- ld_err  out  1  one-cycle pulse; load aborted or restarted.
- swap_req  in  1  commit shadow to active.
- swap_ack  out  1  one-cycle pulse; swap performed.
- rd_en  in  1  read strobe.
- rd_sec  in  $clog2(SOS_NUM)  section index.
- rd_valid  out  1  read data valid.
- rd_b0, rd_b1, rd_b2, rd_a1, rd_a2  out  IIR_WD each  widened coefficients.
- bank_sel  out  1  index of the active bank.

Behaviour:
- Reset (async, rst=1):
  - Both banks cleared to 0; bank_sel=0; state IDLE; word counter 0.
  - All outputs 0.
  - Reset mid-load discards the partial shadow.
- Storage: two banks of SOS_NUM x 5 words each, held widened.
  - Widening: sign-extend ld_data to IIR_WD, then shift left by FRAC_SHIFT; low bits zero.
- Load order: section 0 {b0,b1,b2,a1,a2}, then section 1, and so on; 5*SOS_NUM words in total.
- A word transfers on a clk edge with ld_valid & ld_ready.
- States:
  - IDLE: ld_ready=0. ld_start -> LOAD, counter=0.
  - LOAD: ld_ready=1. Each transfer writes shadow[counter] and increments the counter. The transfer of word 5*SOS_NUM-1 -> FULL, with ld_done=1 in the following cycle.
  - FULL: ld_ready=0. swap_req -> bank_sel toggles, swap_ack=1 next cycle, state IDLE.
- Abort and priority rules:
  - ld_start in LOAD: counter reset to 0, ld_err pulse, stay in LOAD. A transfer in the same cycle is discarded.
  - ld_start in FULL without swap_req: shadow discarded, ld_err pulse, -> LOAD.
  - swap_req and ld_start together in FULL: swap has priority (bank toggles, swap_ack), then -> LOAD into the new shadow, with no ld_err.
  - swap_req in IDLE or LOAD: ignored, swap_ack stays 0.
- Read path:
  - rd_en sampled at edge N; rd_valid and rd_* are presented from edge N, i.e. 1-cycle latency, registered.
  - Reads use bank_sel as sampled at the same edge, so a read coinciding with the swap edge returns the old bank.
  - rd_sec >= SOS_NUM: rd_valid=1, all rd_* = 0.
  - rd_en=0: rd_valid=0, rd_* hold their previous value.
  - Reads never stall and are independent of load state.
- Shadow writes never alter the active bank.

Optional Feature:
- Macro: IIR_COEF_CHECKSUM_EN.
- With the macro:
  - After the last coefficient, LOAD accepts one extra word: the expected checksum, equal to the sum of all ld_data mod 2^COF_WD.
  - Match -> FULL plus ld_done.
  - Mismatch -> ld_err pulse, -> IDLE, shadow not committable.
  - The checksum accumulator clears on ld_start and on reset.
- Without the macro: FULL is reached immediately after the last coefficient; no checksum word is expected.

Test Plan:
- Reset, then read sections 0..5 -> rd_valid=1 one cycle after rd_en, all rd_* = 0, bank_sel=0.
- Load 30 words with values 1..30 (ld_valid held high), then swap_req -> ld_done once after word 30, swap_ack next cycle, bank_sel=1. Read section 2 -> rd_b0=11<<16, rd_a2=15<<16.
- Load ld_data=32'hFFFF_FFFF (-1) as b0 of section 0, then swap -> rd_b0=48'hFFFF_FFFF_0000. Coefficient -2^31 -> 48'h8000_0000_0000.
- ld_start after 12 words accepted -> ld_err pulse. Reload 30 words with value 7 and swap -> every rd_* = 7<<16, with no trace of the aborted data.
- swap_req during LOAD and in IDLE -> no swap_ack, bank_sel unchanged. Read at the swap edge -> old data; one cycle later -> new data.
- With IIR_COEF_CHECKSUM_EN: words 1..30 plus checksum 465 -> ld_done. Checksum 464 -> ld_err, state IDLE, swap_req ignored.
